// File: rtl/mod_step_counter_pkg.sv
// Shared encodings for the modulo step counter: boundary modes and FSM states.
package mod_step_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Encoding 3 is unassigned and behaves like wrap.
    function automatic logic is_wrap(input logic [1:0] mode);
        return !((mode == MODE_SAT) || (mode == MODE_ONESHOT));
    endfunction

endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count and boundary-event computation for one up or down step.
module mod_step_next
    import mod_step_counter_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] count,
    input  logic [N-1:0] step,
    input  logic [N-1:0] modulus,
    input  logic [1:0]   mode,
    input  logic         dir_up,
    output logic [N-1:0] nxt_count_c,
    output logic         event_c
);

    localparam int unsigned W = N + 1;

    logic [N-1:0] s;
    logic [W-1:0] raw;
    logic [W-1:0] mod_p1;

    // A zero effective step never crosses a boundary, so it degenerates to a hold.
    always_comb begin
        s           = (step > modulus) ? modulus : step;
        raw         = {1'b0, count} + {1'b0, s};
        mod_p1      = {1'b0, modulus} + W'(1);
        nxt_count_c = count;
        event_c     = 1'b0;
        if (dir_up) begin
            if (raw <= {1'b0, modulus}) begin
                nxt_count_c = raw[N-1:0];
            end else begin
                event_c     = 1'b1;
                nxt_count_c = is_wrap(mode) ? N'(raw - mod_p1) : modulus;
            end
        end else begin
            if (count >= s) begin
                nxt_count_c = count - s;
            end else begin
                event_c     = 1'b1;
                nxt_count_c = is_wrap(mode) ? N'({1'b0, count} + mod_p1 - {1'b0, s}) : '0;
            end
        end
    end

endmodule

// File: rtl/mod_step_counter.sv
// Modulo up/down step counter with wrap/saturate/one-shot boundaries and load/preset/clamp.
module mod_step_counter
    import mod_step_counter_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned PRESET_VAL = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         down,
    input  logic         load,
    input  logic         preset,
    input  logic [N-1:0] l_data,
    input  logic [N-1:0] step,
    input  logic [N-1:0] modulus,
    input  logic [1:0]   mode,
    output logic [N-1:0] count,
    output logic         max,
    output logic         min,
    output logic         tc,
    output logic         halted
);

    localparam logic [N-1:0] PRESET_N = N'(PRESET_VAL);

    state_e       state;
    state_e       state_nxt;
    logic [N-1:0] count_nxt;
    logic         tc_nxt;
    logic [N-1:0] step_count_c;
    logic         step_event_c;

    mod_step_next #(.N(N)) u_next (
        .count       (count),
        .step        (step),
        .modulus     (modulus),
        .mode        (mode),
        .dir_up      (up),
        .nxt_count_c (step_count_c),
        .event_c     (step_event_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            count <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

    // Priority: load, preset, clamp, single-direction step, else hold.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (en) begin
            if (load) begin
                count_nxt = (l_data > modulus) ? modulus : l_data;
                state_nxt = RUN;
            end else if (preset) begin
                count_nxt = (PRESET_N > modulus) ? modulus : PRESET_N;
                state_nxt = RUN;
            end else if (count > modulus) begin
                count_nxt = modulus;
            end else if ((up ^ down) && (state == RUN)) begin
                count_nxt = step_count_c;
                tc_nxt    = step_event_c;
                if (step_event_c && (mode == MODE_ONESHOT)) begin
                    state_nxt = HALT;
                end
            end
        end
    end

    assign halted = (state == HALT);
    assign max    = (count == modulus);
    assign min    = (count == '0);

endmodule

// File: doc/mod_step_counter.md
MOD_STEP_COUNTER -- requirements
Module: mod_step_counter

Interface
REQ-001 SHALL have parameter N, default 8, meaning count/data width in bits (N >= 2).
REQ-002 SHALL have parameter PRESET_VAL, default 10, meaning value taken on preset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  global enable; when 0, all other controls are ignored and state holds.
REQ-006 SHALL have ports up and down, each  input  1  count-direction requests.
REQ-007 SHALL have port load  input  1  load l_data.
REQ-008 SHALL have port preset  input  1  load PRESET_VAL.
REQ-009 SHALL have port l_data  input  N  load value.
REQ-010 SHALL have port step  input  N  increment/decrement magnitude.
REQ-011 SHALL have port modulus  input  N  upper bound; the legal count range is 0..modulus inclusive.
REQ-012 SHALL have port mode  input  2  boundary mode: 0 wrap, 1 saturate, 2 one-shot, 3 treated as wrap.
REQ-013 SHALL have port count  output  N  registered count value.
REQ-014 SHALL have ports max and min, each  output  1  combinational flags: count==modulus and count==0 respectively.
REQ-015 SHALL have port tc  output  1  registered terminal-count flag, high for one cycle per boundary event.
REQ-016 SHALL have port halted  output  1  registered; high while the one-shot FSM is in HALT.

Function
REQ-017 SHALL apply an effective step s = min(step, modulus); s == 0 SHALL make up/down a hold with no tc.
REQ-018 SHALL use the following priority when en=1: load, then preset, then clamp, then up XOR down, otherwise hold; up&down together SHALL hold.
REQ-019 On load, SHALL set count to min(l_data, modulus); on preset, SHALL set count to min(PRESET_VAL, modulus); both SHALL clear HALT and SHALL NOT pulse tc.
REQ-020 Clamp: if count > modulus (modulus lowered at runtime), SHALL set count to modulus with no tc.
REQ-021 Up: SHALL compute raw = count + s in N+1 bits; if raw <= modulus, count takes raw; otherwise it is an overflow event.
REQ-022 Down: if count >= s, count takes count - s; otherwise it is an underflow event.
REQ-023 Overflow: wrap mode SHALL set count to raw - (modulus+1); saturate and one-shot modes SHALL set count to modulus.
REQ-024 Underflow: wrap mode SHALL set count to count + (modulus+1) - s; saturate and one-shot modes SHALL set count to 0.
REQ-025 Every overflow/underflow event SHALL set tc=1 on the same edge that updates count; tc SHALL be 0 otherwise, including repeated saturated steps, which each pulse.
REQ-026 The FSM SHALL have two states, RUN and HALT; it SHALL go RUN->HALT on an overflow/underflow event in one-shot mode, and HALT->RUN only on load, preset or reset.
REQ-027 In HALT, up/down SHALL be ignored (count holds, tc=0), regardless of the current value of mode.
REQ-028 Latency: count, tc and halted SHALL reflect a request one clock edge after it is sampled; max and min SHALL follow count combinationally.

Reset
REQ-029 Reset SHALL have priority over en and all controls.
REQ-030 Reset SHALL set count=0, tc=0, halted=0 and FSM=RUN, giving min=1 and max=(modulus==0).
REQ-031 Reset asserted mid-count or during HALT SHALL take effect on the next edge with no residual tc.

Structure
REQ-032 Mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state enum (RUN, HALT) SHALL live in package mod_step_counter_pkg.
REQ-033 The combinational next-value and event computation (REQ-017, REQ-021..REQ-024) SHALL be a sub-module named mod_step_next; the FSM and registers SHALL stay in mod_step_counter.

Verification (N=8)
REQ-034 Reset: assert reset for 2 cycles with en=1, up=1 -> count=0, min=1, tc=0, halted=0.
REQ-035 Wrap: modulus=9, step=3, mode=0, up for 4 cycles from 0 -> count 3, 6, 9, 2; tc=1 only with count=2.
REQ-036 Saturate: load 5, then modulus=9, step=2, mode=1, down for 4 cycles -> 3, 1, 0, 0; tc=1 on the last two.
REQ-037 One-shot: modulus=4, step=1, mode=2, up for 6 cycles -> 1, 2, 3, 4, 4(tc=1, halted=1), 4(tc=0); then load l_data=2 -> count=2, halted=0.
REQ-038 Priority/clamp: en=0 with load=1 -> hold; up&down -> hold; load=1 and up=1 with l_data=7 -> 7; modulus dropped from 9 to 5 at count=8 -> 5, tc=0; l_data=200 with modulus=9 -> 9.
REQ-039 Step edge cases: step=0 -> hold with no tc; step=20 with modulus=9, mode=0 from count 4, up -> 3 (s=9), tc=1.
